key_schedule_stream: RTL and testbench
======================================

Name: key_schedule_stream

Overview:
- Iterative, parametrised AES-128 key expansion engine. Computes one round key per clock and holds all round keys in an internal buffer.
- Streams keys out over a valid/ready handshake and also exposes a random-access read port.
- Successor to the fixed five-round key generator: round count is configurable, work starts on request, and the output supports backpressure.
- Feeds the round pipeline of the cipher datapath. Uses the shared externally supplied S-box table.

Parameters:
- NUM_ROUNDS, default 10: number of expanded round keys after key 0; legal range 1..10.
- IDX_W, default 4: width of round index ports; must satisfy 2**IDX_W > NUM_ROUNDS.

Ports:
- clk  in  1  — clock, rising edge.
- rst  in  1  — asynchronous, active-low reset.
- key_initial  in  128  — cipher key; sampled only on start acceptance.
- start  in  1  — request an expansion.
- sub_table  in  128 x [16]  — S-box. Byte b maps to sub_table[b[7:4]][127-8*b[3:0] -: 8].
- substitution_table_valid  in  1  — S-box contents usable.
- busy  out  1  — job in progress.
- done  out  1  — single-cycle pulse at job end.
- table_err  out  1  — single-cycle pulse: start rejected because the table was invalid.
- key_out  out  128  — streamed round key.
- key_out_idx  out  IDX_W  — round number of key_out.
- key_out_valid  out  1  — stream valid.
- key_out_ready  in  1  — stream ready.
- rd_idx  in  IDX_W  — random-access index.
- rd_key  out  128  — buf[rd_idx], combinational; 0 if rd_idx > NUM_ROUNDS.
- rd_valid  out  1  — buf[rd_idx] written during the current or last job.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy, done, table_err, key_out_valid = 0. key_out = 0, key_out_idx = 0. All buffer-written flags cleared, so rd_valid = 0. Buffer data need not be cleared.
- States: IDLE, EXPAND, DRAIN.
- IDLE → EXPAND: on start=1 with substitution_table_valid=1.
  - At that edge: buf[0] = key_initial, flags cleared then flag[0] set, round counter r=1, stream pointer s=0, busy=1.
- IDLE, table invalid: start=1 with substitution_table_valid=0 is ignored and table_err pulses on the next cycle.
- start while busy is ignored; no error is raised.
- EXPAND, one round per cycle while substitution_table_valid=1. Words of buf[r-1] are w0..w3, with w0 = bits [127:96].
  - t = SubWord(RotWord(w3)) ^ {RCON[r],24'h0}, where RCON = 01,02,04,08,10,20,40,80,1B,36.
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2.
  - buf[r] = {n0,n1,n2,n3}; flag[r] set; r increments.
  - After writing r=NUM_ROUNDS, go to DRAIN.
  - If substitution_table_valid=0, expansion stalls: r held, nothing written. Streaming continues.
- Latency: start accepted at edge T. buf[k] is written at edge T+k. Expansion completes at edge T+NUM_ROUNDS.
- Streaming (normal order) runs concurrently with expansion.
  - key_out_valid=1 whenever flag[s]=1 and s ≤ NUM_ROUNDS. key_out=buf[s], key_out_idx=s.
  - A transfer occurs on valid&ready; s then increments.
  - key_out and key_out_idx are stable while valid=1 and ready=0.
  - With ready held high, key k appears in cycle T+1+k. Back-to-back, no bubbles.
- DRAIN → IDLE: after the transfer of index NUM_ROUNDS. done=1 and busy=0 in the following cycle; key_out_valid=0.
- Keys remain readable via rd_* after done until the next start. A new start overwrites the buffer.
- Reset mid-job aborts immediately with the reset values above. No partial done.

Optional Feature:
- Macro: KEYGEN_DEC_ORDER_EN.
- Defined:
  - Adds input port dec_order (1 bit), sampled at start acceptance.
  - If dec_order=1, streaming is held off (key_out_valid=0) until expansion completes. Keys are then emitted in order NUM_ROUNDS down to 0; key_out_idx reflects the true round number.
  - The job ends after key 0 is accepted.
  - dec_order=0 behaves as normal order.
- Not defined: no dec_order port; normal order only.

Test Plan:
- FIPS-197 key: key_initial=2B7E151628AED2A6ABF7158809CF4F3C, NUM_ROUNDS=10, ready=1.
  - Keys idx 0..10 in 11 consecutive cycles.
  - idx1 = A0FAFE1788542CB123A339392A6C7605; idx10 = D014F9A8C9EE2589E13F0CC8B6630CA6.
  - done pulses once, one cycle after idx10.
- Backpressure: same key, ready toggles 1,0,0,1,... → key_out and key_out_idx stable during stalls. No key lost or duplicated; same 11 values.
- Table gating:
  - start with substitution_table_valid=0 → table_err pulse, busy stays 0.
  - Drop valid for 3 cycles mid-expansion → completion delayed exactly 3 cycles; keys unchanged.
- NUM_ROUNDS=4 build: rd_idx=4 after done → rd_key=EF44A541A8525B7FB671253BDB0BAD00, rd_valid=1. rd_idx=5 → rd_key=0.
- Reset: rst=0 at cycle T+5 → outputs at reset values immediately; new start afterwards yields correct full sequence.
- KEYGEN_DEC_ORDER_EN defined, dec_order=1 → first key_out_valid at T+11 with idx10 = D014F9A8…; last is idx0 = 2B7E1516…; then done.

Source files
------------

// File: rtl/key_schedule_stream.sv
// key_schedule_stream
//   Iterative AES-128 key expansion. After a start is accepted, one round
//   key is produced per clock into an internal buffer. Keys are streamed out
//   over a valid/ready handshake while expansion is still running, and every
//   key can also be read at random through the rd_* port.
//
// Optional feature macro: KEYGEN_DEC_ORDER_EN
//   When defined, adds the dec_order input. A job started with dec_order=1
//   streams keys from NUM_ROUNDS down to 0, beginning only after expansion
//   has finished. Without the macro only normal order exists.
//
// Ports
//   clk                      clock, rising edge
//   rst                      asynchronous reset, active low
//   key_initial[127:0]       cipher key, sampled when start is accepted
//   start                    request an expansion
//   dec_order                (macro only) stream in decryption order
//   sub_table[16][127:0]     shared S-box; byte b at [b[7:4]][127-8*b[3:0] -: 8]
//   substitution_table_valid S-box contents usable; gates start and expansion
//   busy                     job in progress
//   done                     one-cycle pulse when a job ends
//   table_err                one-cycle pulse when start met an invalid table
//   key_out / key_out_idx    streamed round key and its round number
//   key_out_valid/ready      stream handshake
//   rd_idx / rd_key          random-access read (combinational)
//   rd_valid                 buffer entry rd_idx written in current/last job
module key_schedule_stream #(
  parameter int NUM_ROUNDS = 10,
  parameter int IDX_W      = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [127:0]       key_initial,
  input  logic               start,
`ifdef KEYGEN_DEC_ORDER_EN
  input  logic               dec_order,
`endif
  input  logic [127:0]       sub_table [16],
  input  logic               substitution_table_valid,
  output logic               busy,
  output logic               done,
  output logic               table_err,
  output logic [127:0]       key_out,
  output logic [IDX_W-1:0]   key_out_idx,
  output logic               key_out_valid,
  input  logic               key_out_ready,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [127:0]       rd_key,
  output logic               rd_valid
);

  // Buffer and flags span the whole index space so every index is in bounds;
  // entries above NUM_ROUNDS are never written and are masked on read.
  localparam int               DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_ROUNDS);

  typedef enum logic [1:0] {IDLE, EXPAND, DRAIN} state_t;

  state_t             state_reg, state_next;
  logic [127:0]       key_buf [DEPTH];
  logic [DEPTH-1:0]   flag_reg;
  logic [IDX_W-1:0]   r_reg;        // next round to compute
  logic [IDX_W-1:0]   s_reg;        // round number currently offered on the stream
  logic               done_reg, err_reg;
  logic               accept, step_en, err_next, done_next;
  logic               xfer, last_xfer, s_in_range;
  logic               dec_mode, dec_start;

`ifdef KEYGEN_DEC_ORDER_EN
  logic dec_reg;
  assign dec_start = dec_order;
  assign dec_mode  = dec_reg;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dec_reg <= 1'b0;
    else if (accept) dec_reg <= dec_order;
  end
`else
  assign dec_start = 1'b0;
  assign dec_mode  = 1'b0;
`endif

  // ---------------- round function on buf[r-1] ----------------
  logic [127:0] prev_key, next_key;
  logic [31:0]  w0, w1, w2, w3, rot_w, sub_w, t_w, n0, n1, n2, n3;
  logic [7:0]   rcon;

  assign prev_key = key_buf[r_reg - IDX_W'(1)];
  assign {w0, w1, w2, w3} = prev_key;
  assign rot_w = {w3[23:0], w3[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_sub
      logic [7:0] sb_in;
      assign sb_in = rot_w[8*gi +: 8];
      assign sub_w[8*gi +: 8] = sub_table[sb_in[7:4]][7'd127 - {sb_in[3:0], 3'b000} -: 8];
    end
  endgenerate

  // RCON[r] = x^(r-1) in GF(2^8): repeated doubling, r in 1..10
  always_comb begin
    rcon = 8'h01;
    for (int i = 2; i <= 10; i++) begin
      if (i <= int'(r_reg)) rcon = {rcon[6:0], 1'b0} ^ (8'h1b & {8{rcon[7]}});
    end
  end

  assign t_w      = sub_w ^ {rcon, 24'h0};
  assign n0       = w0 ^ t_w;
  assign n1       = w1 ^ n0;
  assign n2       = w2 ^ n1;
  assign n3       = w3 ^ n2;
  assign next_key = {n0, n1, n2, n3};

  // ---------------- stream side ----------------
  assign s_in_range    = (s_reg <= LAST);
  assign key_out_valid = (state_reg != IDLE) && s_in_range && flag_reg[s_reg]
                         && (!dec_mode || state_reg == DRAIN);
  assign xfer          = key_out_valid && key_out_ready;
  assign last_xfer     = xfer && (s_reg == (dec_mode ? '0 : LAST));
  assign key_out       = key_out_valid ? key_buf[s_reg] : '0;
  assign key_out_idx   = s_reg;

  assign rd_key   = (rd_idx <= LAST) ? key_buf[rd_idx] : '0;
  assign rd_valid = (rd_idx <= LAST) && flag_reg[rd_idx];

  assign busy      = (state_reg != IDLE);
  assign done      = done_reg;
  assign table_err = err_reg;

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    step_en    = 1'b0;
    err_next   = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (substitution_table_valid) begin
            accept     = 1'b1;
            state_next = EXPAND;
          end else begin
            err_next = 1'b1;
          end
        end
      end
      EXPAND: begin
        if (substitution_table_valid) begin
          step_en = 1'b1;
          if (r_reg == LAST) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_xfer) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      r_reg     <= '0;
      s_reg     <= '0;
      flag_reg  <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      if (accept) begin
        r_reg    <= IDX_W'(1);
        flag_reg <= DEPTH'(1);
      end else if (step_en) begin
        r_reg           <= r_reg + IDX_W'(1);
        flag_reg[r_reg] <= 1'b1;
      end
      if (accept)
        s_reg <= dec_start ? LAST : '0;
      else if (xfer)
        s_reg <= last_xfer ? '0 : (dec_mode ? s_reg - IDX_W'(1) : s_reg + IDX_W'(1));
    end
  end

  // Key storage has no reset; validity is tracked by flag_reg.
  always_ff @(posedge clk) begin
    if (accept)       key_buf[0]     <= key_initial;
    else if (step_en) key_buf[r_reg] <= next_key;
  end

endmodule

// File: tb/tb_key_schedule_stream.sv
module tb_key_schedule_stream;

  localparam logic [127:0] FIPS_KEY = 128'h2B7E151628AED2A6ABF7158809CF4F3C;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] key_initial;
  logic         start;
`ifdef KEYGEN_DEC_ORDER_EN
  logic         dec_order;
`endif
  logic [127:0] sub_table [16];
  logic         tbl_valid;
  logic         busy, done, table_err;
  logic [127:0] key_out;
  logic [3:0]   key_out_idx;
  logic         key_out_valid, key_out_ready;
  logic [3:0]   rd_idx;
  logic [127:0] rd_key;
  logic         rd_valid;

  // second instance built with NUM_ROUNDS=4
  logic [127:0] key4;
  logic         start4, busy4, done4, table_err4;
  logic [127:0] key_out4;
  logic [3:0]   key_out_idx4;
  logic         key_out_valid4, key_out_ready4;
  logic [3:0]   rd_idx4;
  logic [127:0] rd_key4;
  logic         rd_valid4;

  key_schedule_stream dut (
    .clk(clk), .rst(rst), .key_initial(key_initial), .start(start),
`ifdef KEYGEN_DEC_ORDER_EN
    .dec_order(dec_order),
`endif
    .sub_table(sub_table), .substitution_table_valid(tbl_valid),
    .busy(busy), .done(done), .table_err(table_err),
    .key_out(key_out), .key_out_idx(key_out_idx),
    .key_out_valid(key_out_valid), .key_out_ready(key_out_ready),
    .rd_idx(rd_idx), .rd_key(rd_key), .rd_valid(rd_valid)
  );

  key_schedule_stream #(.NUM_ROUNDS(4)) dut4 (
    .clk(clk), .rst(rst), .key_initial(key4), .start(start4),
`ifdef KEYGEN_DEC_ORDER_EN
    .dec_order(1'b0),
`endif
    .sub_table(sub_table), .substitution_table_valid(tbl_valid),
    .busy(busy4), .done(done4), .table_err(table_err4),
    .key_out(key_out4), .key_out_idx(key_out_idx4),
    .key_out_valid(key_out_valid4), .key_out_ready(key_out_ready4),
    .rd_idx(rd_idx4), .rd_key(rd_key4), .rd_valid(rd_valid4)
  );

  int tests = 0;
  int fails = 0;
  logic [7:0]   sbox_arr [256];
  logic [127:0] model_keys [0:10];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map
  function automatic logic [7:0] sbox_of(input logic [7:0] x);
    logic [7:0] inv, s, tmp;
    inv = 8'h00;
    if (x != 8'h00)
      for (int y = 1; y < 256; y++)
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    s = inv ^ 8'h63;
    for (int i = 1; i <= 4; i++) begin
      tmp = (inv << i) | (inv >> (8 - i));
      s = s ^ tmp;
    end
    return s;
  endfunction

  // FIPS-197 word-wise expansion
  task automatic compute_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc [10];
    rc = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox_arr[tmp[31:24]], sbox_arr[tmp[23:16]], sbox_arr[tmp[15:8]], sbox_arr[tmp[7:0]]};
        tmp = tmp ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) model_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // mode 0: ready=1, mode 1: ready 1,0,0 repeating, mode 2: random ready
  task automatic run_job(input logic [127:0] k, input int mode, input bit dec,
                         input int stall_at, input int stall_len,
                         output int done_cyc, output int first_cyc);
    logic [127:0] got_key [$];
    int           got_idx [$];
    logic [127:0] pk;
    logic [3:0]   pidx;
    logic         pv, pr;
    int           n, e;
    compute_model(k);
    key_initial = k;
    start = 1'b1;
    tbl_valid = 1'b1;
`ifdef KEYGEN_DEC_ORDER_EN
    dec_order = dec;
`endif
    step();
    start = 1'b0;
    key_initial = ~k;
    chk("busy_after_start", busy, 1);
    pv = 1'b0; pr = 1'b0; pk = '0; pidx = '0;
    done_cyc = -1; first_cyc = -1;
    for (int c = 1; c <= 300 && done_cyc < 0; c++) begin
      tbl_valid = !(stall_len > 0 && c >= stall_at && c < stall_at + stall_len);
      case (mode)
        0:       key_out_ready = 1'b1;
        1:       key_out_ready = (c % 3 == 1);
        default: key_out_ready = 1'($urandom_range(0, 1));
      endcase
      start = (c == 3);
      if (pv && !pr) begin
        chk("stall_valid", key_out_valid, 1);
        chk("stall_key", key_out, pk);
        chk("stall_idx", key_out_idx, pidx);
      end
      if (key_out_valid && first_cyc < 0) first_cyc = c;
      if (key_out_valid && key_out_ready) begin
        got_key.push_back(key_out);
        got_idx.push_back(int'(key_out_idx));
        $display("[TB] xfer idx=%0d key=%h cycle=%0d", key_out_idx, key_out, c);
      end
      pv = key_out_valid; pr = key_out_ready; pk = key_out; pidx = key_out_idx;
      step();
      if (done) done_cyc = c;
    end
    start = 1'b0;
    tbl_valid = 1'b1;
    key_out_ready = 1'b1;
    chk("done_seen", done_cyc >= 0, 1);
    chk("busy_at_done", busy, 0);
    chk("valid_at_done", key_out_valid, 0);
    step();
    chk("done_single_pulse", done, 0);
    chk("key_count", got_key.size(), 11);
    n = (got_key.size() < 11) ? got_key.size() : 11;
    for (int i = 0; i < n; i++) begin
      e = dec ? 10 - i : i;
      chk("stream_idx", got_idx[i], e);
      chk("stream_key", got_key[i], model_keys[e]);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_table_err", table_err, 0);
    chk("rst_valid", key_out_valid, 0);
    chk("rst_key_out", key_out, 0);
    chk("rst_key_idx", key_out_idx, 0);
    chk("rst_rd_valid", rd_valid, 0);
  endtask

  initial begin
    int dc, fc, sa, sl, d4;
    logic [127:0] rk;

    for (int b = 0; b < 256; b++) sbox_arr[b] = sbox_of(8'(b));
    for (int b = 0; b < 256; b++) sub_table[b / 16][127 - 8*(b % 16) -: 8] = sbox_arr[b];

    rst = 1'b0; start = 1'b0; key_initial = '0; tbl_valid = 1'b1;
    key_out_ready = 1'b1; rd_idx = '0;
`ifdef KEYGEN_DEC_ORDER_EN
    dec_order = 1'b0;
`endif
    key4 = '0; start4 = 1'b0; key_out_ready4 = 1'b1; rd_idx4 = '0;
    step(); step();
    check_reset_values();
    rst = 1'b1;
    step();

    // start refused with an invalid table
    tbl_valid = 1'b0; start = 1'b1;
    step();
    chk("table_err_pulse", table_err, 1);
    chk("table_err_busy", busy, 0);
    start = 1'b0; tbl_valid = 1'b1;
    step();
    chk("table_err_single", table_err, 0);
    chk("table_err_busy2", busy, 0);

    // FIPS-197 key, ready held high
    run_job(FIPS_KEY, 0, 1'b0, 0, 0, dc, fc);
    chk("fips_first_valid_cycle", fc, 1);
    chk("fips_done_cycle", dc, 11);
    rd_idx = 4'd1; #1;
    chk("fips_idx1", rd_key, 128'hA0FAFE1788542CB123A339392A6C7605);
    rd_idx = 4'd10; #1;
    chk("fips_idx10", rd_key, 128'hD014F9A8C9EE2589E13F0CC8B6630CA6);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i); #1;
      rk = (i <= 10) ? model_keys[i] : '0;
      chk("rd_key_sweep", rd_key, rk);
      chk("rd_valid_sweep", rd_valid, (i <= 10));
    end

    // backpressure pattern 1,0,0
    run_job(FIPS_KEY, 1, 1'b0, 0, 0, dc, fc);

    // table dropped for 3 cycles mid-expansion
    run_job(FIPS_KEY, 0, 1'b0, 4, 3, dc, fc);
    chk("stall_done_cycle", dc, 14);

    // random keys, random ready, random stalls
    for (int j = 0; j < 3; j++) begin
      sa = $urandom_range(2, 8);
      sl = $urandom_range(0, 3);
      run_job({$urandom, $urandom, $urandom, $urandom}, 2, 1'b0, sa, sl, dc, fc);
    end

    // reset in the middle of a job
    key_initial = FIPS_KEY; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rd_idx = 4'd0;
    #2 rst = 1'b0;
    #1;
    check_reset_values();
    step();
    chk("rst_no_done", done, 0);
    rst = 1'b1;
    step();
    run_job(FIPS_KEY, 0, 1'b0, 0, 0, dc, fc);
    chk("after_rst_done_cycle", dc, 11);

    // NUM_ROUNDS=4 instance
    compute_model(FIPS_KEY);
    key4 = FIPS_KEY; start4 = 1'b1;
    step();
    start4 = 1'b0;
    d4 = 0;
    for (int c = 1; c <= 60 && d4 == 0; c++) begin
      if (key_out_valid4) begin
        chk("n4_stream_key", key_out4, model_keys[key_out_idx4]);
        $display("[TB] n4 xfer idx=%0d key=%h", key_out_idx4, key_out4);
      end
      step();
      if (done4) d4 = 1;
    end
    chk("n4_done", d4, 1);
    chk("n4_busy", busy4, 0);
    chk("n4_table_err", table_err4, 0);
    rd_idx4 = 4'd4; #1;
    chk("n4_rd_key4", rd_key4, 128'hEF44A541A8525B7FB671253BDB0BAD00);
    chk("n4_rd_valid4", rd_valid4, 1);
    rd_idx4 = 4'd5; #1;
    chk("n4_rd_key5", rd_key4, 0);
    chk("n4_rd_valid5", rd_valid4, 0);

`ifdef KEYGEN_DEC_ORDER_EN
    run_job(FIPS_KEY, 0, 1'b1, 0, 0, dc, fc);
    chk("dec_first_valid_cycle", fc, 11);
    chk("dec_done_cycle", dc, 21);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
